multdiv_unit: RTL
=================

// Module: multdiv_unit
// PURPOSE
//  Multi-cycle signed 32-bit multiplier/divider in the execute stage, in parallel with the ALU.
//  Its result and exception flag feed the X/M latch o_in path. busy drives the stall/enable
//  logic that freezes the F/D, D/X and X/M latches while an operation runs.
//  mul: radix-4 Booth. div: restoring divide on magnitudes, then a sign fix-up.
// PARAMETERS
//  WIDTH     32  operand/result width; only 32 is supported (MUL_ITERS/DIV_ITERS derive from it)
//  MUL_ITERS 16  Booth iterations (WIDTH/2)
//  DIV_ITERS 32  divide iterations (WIDTH)
// PORTS
//  clock         in   1      single clock, rising edge
//  reset         in   1      synchronous, ACTIVE-LOW; sampled on rising clock edge only
//  ctrl_mult     in   1      start multiply; sampled only in IDLE/DONE
//  ctrl_div      in   1      start divide; sampled only in IDLE/DONE
//  operand_a     in   WIDTH  multiplicand / dividend (signed), captured at start edge
//  operand_b     in   WIDTH  multiplier / divisor (signed), captured at start edge
//  result        out  WIDTH  low 32 bits of product, or quotient truncated toward zero
//  exception     out  1      mul overflow, div by zero, or INT_MIN / -1
//  result_ready  out  1      one-cycle pulse: result/exception valid from this cycle
//  busy          out  1      op in flight; pipeline stall request
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, result=0, exception=0, result_ready=0, busy=0, counter=0.
//   Aborts any op in flight, with no result_ready.
//  States: IDLE, MULT, DIV, FIXUP, DONE. All outputs are registered.
//  Start edge E0 (state IDLE or DONE):
//   ctrl_mult=1 -> capture operands, acc=0, counter=0, go to MULT. ctrl_mult has priority if both are high.
//   ctrl_div=1, b!=0 -> store |a| and |b|, remember the quotient sign, go to DIV.
//   ctrl_div=1, b==0 -> go straight to DONE with result=0, exception=1.
//  MULT: each edge consumes 3 multiplier bits (overlapping) and adds 0/+-A/+-2A into a 66-bit accumulator.
//   The accumulator then shifts right arithmetically by 2. After edge E16 (counter==15) go to DONE.
//   result = product[31:0].
//   exception = 1 iff product[63:32] is not all copies of product[31].
//  DIV: each edge does shift remainder/quotient left by 1, trial-subtract |b|, set the quotient bit.
//   After edge E32 go to FIXUP.
//  FIXUP (one edge, E33): result = sign ? -q : q.
//   exception = 1 iff a==0x80000000 && b==0xFFFFFFFF; result is then 0x80000000.
//   Go to DONE.
//  DONE: result_ready=1 for exactly this cycle. Outputs hold until the next start.
//   Without a start, the next edge returns to IDLE and result_ready drops to 0.
//  Latency: a mul start at E0 gives result_ready high in the cycle after E16.
//   A div (b!=0) gives it in the cycle after E33. A div by zero gives it in the cycle after E0.
//  busy = 1 in MULT, DIV and FIXUP; 0 in IDLE and DONE.
//   busy rises in the cycle after E0 and falls in the same cycle result_ready rises.
//  Start while busy: ignored. Operands are not recaptured and the current op is unaffected.
//  Back-to-back: a start sampled in DONE is accepted. result_ready pulses, and the new op begins.
//  All arithmetic is two's complement. The counter wraps nowhere, since state exits at the terminal count.
//  Operand inputs may change freely after E0.
// STRUCTURE
//  Shared package (processor-wide defines): state encoding, MUL_ITERS, DIV_ITERS, INT_MIN constant.
//  One sub-module: booth_select.
//   Combinational. Takes 3 multiplier bits and A; returns the partial product (0, +-A, +-2A, 34-bit).
//  The FSM, counter, accumulator and divide datapath stay in multdiv_unit.
//  Existing register and adder blocks may be reused.
// TESTING
//  mul 6*7: start E0 -> result_ready in cycle after E16, result=42, exception=0, busy high E1..E16.
//  mul -3*5 -> result=0xFFFFFFF1 (-15), exception=0.
//  mul 0x00010000*0x00010000 -> result=0x00000000, exception=1.
//  mul 0x7FFFFFFF*-1 -> result=0x80000001, exception=0.
//  div 7/-2 -> result=0xFFFFFFFD (-3), ready after E33, exception=0.
//  div -7/2 -> result=-3, exception=0.
//  div 5/0 -> result=0, exception=1, result_ready in cycle after E0, busy never high.
//  div 0x80000000/0xFFFFFFFF -> result=0x80000000, exception=1.
//  Start during MULT (ctrl_div pulse at E5) -> ignored; the mul result is unchanged and the ready timing holds.
//  reset=0 at E8 of a div -> all outputs 0 and IDLE next cycle, no result_ready.
//   A new mul started after reset then completes correctly.
//  Back-to-back: ctrl_mult held high in the DONE cycle -> second op starts, busy high the next cycle.

Source files
------------

// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   state_t    FSM state encoding
//   MUL_ITERS  radix-4 Booth iterations for a 32-bit multiplier
//   DIV_ITERS  restoring-divide iterations for a 32-bit dividend
//   INT_MIN    most negative 32-bit two's complement value
// -----------------------------------------------------------------------------
package multdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int          MUL_ITERS = 16;
  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/multdiv_unit_booth_select.sv
// -----------------------------------------------------------------------------
// booth_select
// Combinational radix-4 Booth partial-product selector.
// Ports:
//   bits   in   3        overlapping multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   mcand  in   WIDTH    signed multiplicand A
//   pp     out  WIDTH+2  signed partial product: 0, +A, +2A, -A or -2A
// -----------------------------------------------------------------------------
module booth_select #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       bits,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH+1:0] pp
);

  logic signed [WIDTH+1:0] a_ext;
  logic signed [WIDTH+1:0] a_dbl;

  // Two guard bits so that -2*INT_MIN stays representable.
  assign a_ext = $signed({{2{mcand[WIDTH-1]}}, mcand});
  assign a_dbl = a_ext <<< 1;

  always_comb begin
    pp = '0;
    case (bits)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_dbl;
      3'b100:         pp = -a_dbl;
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
// Multi-cycle signed 32-bit multiplier/divider running beside the ALU.
//   mul: radix-4 Booth, 16 iterations, low 32 product bits returned.
//   div: restoring divide on magnitudes (32 iterations) plus a sign fix-up.
// Ports:
//   clock         in   1      rising-edge clock
//   reset         in   1      synchronous, active-low
//   ctrl_mult     in   1      start multiply (sampled in IDLE/DONE, wins over ctrl_div)
//   ctrl_div      in   1      start divide   (sampled in IDLE/DONE)
//   operand_a     in   WIDTH  multiplicand / dividend, captured at the start edge
//   operand_b     in   WIDTH  multiplier / divisor, captured at the start edge
//   result        out  WIDTH  low product word or quotient (truncated toward zero)
//   exception     out  1      mul overflow, divide by zero, or INT_MIN / -1
//   result_ready  out  1      single-cycle pulse when result/exception become valid
//   busy          out  1      operation in flight; stalls the pipeline latches
// -----------------------------------------------------------------------------
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_ready,
  output logic             busy
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_ITERS - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

  state_t     state;
  logic [5:0] counter;

  // Multiply datapath: acc = {hi[WIDTH+1:0], multiplier shift reg[WIDTH-1:0]}.
  logic [2*WIDTH+1:0] acc;
  logic               q_m1;
  logic [WIDTH-1:0]   mcand;

  // Divide datapath.
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               q_neg;
  logic               div_ovf;

  logic                      accept;
  logic [WIDTH+1:0]          pp;
  logic signed [WIDTH+1:0]   mul_hi_sum;
  logic signed [2*WIDTH+1:0] mul_next;
  logic [WIDTH:0]            div_shift;
  logic [WIDTH+1:0]          div_trial;
  logic                      div_ge;

  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] q, input logic neg);
    return neg ? (~q + 1'b1) : q;
  endfunction

  // The 64-bit product fits in 32 bits only if its top 33 bits are all equal.
  function automatic logic mul_overflow(input logic [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || (~|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  assign accept = (state == ST_IDLE) || (state == ST_DONE);

  booth_select #(.WIDTH(WIDTH)) u_booth_select (
    .bits  ({acc[1], acc[0], q_m1}),
    .mcand (mcand),
    .pp    (pp)
  );

  assign mul_hi_sum = $signed(acc[2*WIDTH+1:WIDTH]) + $signed(pp);
  assign mul_next   = $signed({mul_hi_sum, acc[WIDTH-1:0]}) >>> 2;

  // Remainder stays below |b| <= 2^31, so shifting in one quotient bit fits in WIDTH+1.
  assign div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, dvs};
  assign div_ge    = ~div_trial[WIDTH+1];

  // ---- datapath registers (no reset; qualified by FSM state) ----
  always_ff @(posedge clock) begin
    if (accept && ctrl_mult) begin
      mcand <= operand_a;
      acc   <= {{(WIDTH+2){1'b0}}, operand_b};
      q_m1  <= 1'b0;
    end else if (accept && ctrl_div) begin
      rem     <= '0;
      quo     <= abs_mag(operand_a);
      dvs     <= abs_mag(operand_b);
      q_neg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      div_ovf <= (operand_a == INT_MIN) && (operand_b == '1);
    end else if (state == ST_MULT) begin
      acc  <= mul_next;
      q_m1 <= acc[1];
    end else if (state == ST_DIV) begin
      rem <= div_ge ? div_trial[WIDTH:0] : div_shift;
      quo <= {quo[WIDTH-2:0], div_ge};
    end
  end

  // ---- control FSM and registered outputs ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      counter      <= '0;
      result       <= '0;
      exception    <= 1'b0;
      result_ready <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          result_ready <= 1'b0;
          counter      <= '0;
          if (ctrl_mult) begin
            busy  <= 1'b1;
            state <= ST_MULT;
          end else if (ctrl_div) begin
            if (operand_b == '0) begin
              result       <= '0;
              exception    <= 1'b1;
              result_ready <= 1'b1;
              state        <= ST_DONE;
            end else begin
              busy  <= 1'b1;
              state <= ST_DIV;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MULT: begin
          counter <= counter + 6'd1;
          if (counter == MUL_LAST) begin
            result       <= mul_next[WIDTH-1:0];
            exception    <= mul_overflow(mul_next[2*WIDTH-1:0]);
            result_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_DONE;
          end
        end
        ST_DIV: begin
          counter <= counter + 6'd1;
          if (counter == DIV_LAST) begin
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          // INT_MIN / -1 would overflow; the magnitude quotient already is 0x80000000.
          result       <= div_ovf ? INT_MIN : apply_sign(quo, q_neg);
          exception    <= div_ovf;
          result_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
